riscv_prefetch_ctrl: RTL and testbench

Memory-side fetch controller that sits directly upstream of the instruction fetch FIFO. It issues word-aligned instruction requests on the OBI-style instruction port and keeps at most `MAX_OUTSTANDING` requests in flight. Returned words are pushed into the FIFO with their fetch addresses. On a branch it clears the FIFO, retargets fetching and silently drops responses to requests issued before the branch.

---
 rtl/riscv_prefetch_ctrl.sv | 135 +++++++++++++
 tb/tb_riscv_prefetch_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_prefetch_ctrl.sv
// Instruction prefetch controller: issues OBI fetch requests, tracks
// outstanding grants and pushes returned words into the fetch FIFO.
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   req_i                 fetch enable
//   branch_i/_addr_i      redirect request and target
//   instr_req_o/_addr_o   memory request and word-aligned address
//   instr_gnt_i           memory grant
//   instr_rvalid_i/_rdata_i  in-order memory response
//   fifo_valid_o/_addr_o/_rdata_o  push into the fetch FIFO
//   fifo_ready_i          FIFO can accept new words
//   fifo_clear_o          FIFO flush (follows branch_i)
//   busy_o                request pending or outstanding
module riscv_prefetch_ctrl #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int RDATA_WIDTH     = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_i,
  input  logic                   branch_i,
  input  logic [31:0]            branch_addr_i,
  output logic                   instr_req_o,
  output logic [31:0]            instr_addr_o,
  input  logic                   instr_gnt_i,
  input  logic                   instr_rvalid_i,
  input  logic [RDATA_WIDTH-1:0] instr_rdata_i,
  output logic                   fifo_valid_o,
  output logic [31:0]            fifo_addr_o,
  output logic [RDATA_WIDTH-1:0] fifo_rdata_o,
  input  logic                   fifo_ready_i,
  output logic                   fifo_clear_o,
  output logic                   busy_o
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = (MAX_OUTSTANDING > 1) ?
                      $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CW-1:0] MAXC  = CW'(MAX_OUTSTANDING);
  localparam logic [PW-1:0] LASTP = PW'(MAX_OUTSTANDING - 1);

  typedef enum logic {
    IDLE,
    WAIT_GNT
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [31:0]   r_fetch_addr;
  logic [31:0]   r_held_addr;
  logic          r_armed;
  logic [CW-1:0] r_outst;
  logic [CW-1:0] r_disc;
  logic [31:0]   r_aq [MAX_OUTSTANDING];
  logic [PW-1:0] r_wp;
  logic [PW-1:0] r_rp;

  logic [31:0]   w_eff;
  logic          w_req;
  logic          w_gnt;
  logic          w_disc_nz;
  logic          w_drop;
  logic          w_push;

  always_comb begin
    w_eff  = r_fetch_addr;
    w_req  = 1'b0;
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        w_eff = branch_i ? branch_addr_i : r_fetch_addr;
        // nothing is fetched after reset until a target is known
        w_req = (branch_i | (req_i & r_armed)) &
                fifo_ready_i & (r_outst < MAXC);
        if (w_req && !instr_gnt_i) w_next = WAIT_GNT;
      end
      WAIT_GNT: begin
        w_eff = branch_i ? branch_addr_i : r_held_addr;
        w_req = 1'b1;
        if (instr_gnt_i) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_gnt     = w_req & instr_gnt_i;
  assign w_disc_nz = (r_disc != '0);
  assign w_drop    = w_disc_nz | branch_i;
  assign w_push    = instr_rvalid_i & ~w_drop;

  assign instr_req_o  = w_req;
  assign instr_addr_o = {w_eff[31:2], 2'b00};
  assign fifo_valid_o = w_push;
  assign fifo_addr_o  = w_push ? r_aq[r_rp] : 32'h0;
  assign fifo_rdata_o = instr_rdata_i;
  assign fifo_clear_o = branch_i;
  assign busy_o       = (r_state == WAIT_GNT) | (r_outst != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_fetch_addr <= 32'h0;
      r_held_addr  <= 32'h0;
      r_armed      <= 1'b0;
      r_outst      <= '0;
      r_disc       <= '0;
      r_wp         <= '0;
      r_rp         <= '0;
    end else begin
      r_state <= w_next;
      if (branch_i) r_armed <= 1'b1;
      if (w_req && !instr_gnt_i) r_held_addr <= w_eff;
      if (w_gnt) begin
        r_fetch_addr <= {w_eff[31:2], 2'b00} + 32'd4;
        r_wp <= (r_wp == LASTP) ? '0 : r_wp + PW'(1);
      end else if (branch_i) begin
        r_fetch_addr <= branch_addr_i;
      end
      if (instr_rvalid_i)
        r_rp <= (r_rp == LASTP) ? '0 : r_rp + PW'(1);
      r_outst <= r_outst + CW'(w_gnt) - CW'(instr_rvalid_i);
      // a branch marks every older request still unanswered as stale;
      // a grant in the same cycle belongs to the new stream
      if (branch_i)
        r_disc <= r_outst - CW'(instr_rvalid_i);
      else if (instr_rvalid_i && w_disc_nz)
        r_disc <= r_disc - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_gnt) r_aq[r_wp] <= {w_eff[31:1], 1'b0};
  end

endmodule

// File: tb/tb_riscv_prefetch_ctrl.sv
// Testbench for riscv_prefetch_ctrl: directed scenarios plus random
// traffic, checked against a queue-based reference model.
module tb_riscv_prefetch_ctrl;

  localparam int MAXO = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_i;
  logic        branch_i;
  logic [31:0] branch_addr_i;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i;
  logic        instr_rvalid_i;
  logic [31:0] instr_rdata_i;
  logic        fifo_valid_o;
  logic [31:0] fifo_addr_o;
  logic [31:0] fifo_rdata_o;
  logic        fifo_ready_i;
  logic        fifo_clear_o;
  logic        busy_o;

  riscv_prefetch_ctrl #(
    .MAX_OUTSTANDING(MAXO),
    .RDATA_WIDTH(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_i(req_i),
    .branch_i(branch_i),
    .branch_addr_i(branch_addr_i),
    .instr_req_o(instr_req_o),
    .instr_addr_o(instr_addr_o),
    .instr_gnt_i(instr_gnt_i),
    .instr_rvalid_i(instr_rvalid_i),
    .instr_rdata_i(instr_rdata_i),
    .fifo_valid_o(fifo_valid_o),
    .fifo_addr_o(fifo_addr_o),
    .fifo_rdata_o(fifo_rdata_o),
    .fifo_ready_i(fifo_ready_i),
    .fifo_clear_o(fifo_clear_o),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    bit          stale;
  } ent_t;

  ent_t        m_q[$];
  logic [31:0] m_fetch;
  logic [31:0] m_held_a;
  bit          m_held;
  bit          m_armed;
  bit          m_er;
  logic [31:0] m_e;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(string t, logic [31:0] o, logic [31:0] e);
    n_chk++;
    assert (o === e) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", t, o, e);
  endtask

  task automatic mreset();
    m_q.delete();
    m_fetch  = 32'h0;
    m_held_a = 32'h0;
    m_held   = 0;
    m_armed  = 0;
  endtask

  task automatic drv(bit r, bit b, logic [31:0] ba,
                     bit g, bit rd, bit rv);
    req_i          = r;
    branch_i       = b;
    branch_addr_i  = ba;
    instr_gnt_i    = g;
    fifo_ready_i   = rd;
    instr_rvalid_i = rv;
    instr_rdata_i  = $urandom;
  endtask

  // expected outputs for the current inputs, from the model state
  task automatic mcheck();
    bit ev;
    if (m_held) begin
      m_er = 1;
      m_e  = branch_i ? branch_addr_i : m_held_a;
    end else begin
      m_e  = branch_i ? branch_addr_i : m_fetch;
      m_er = (branch_i || (req_i && m_armed)) && fifo_ready_i &&
             (m_q.size() < MAXO);
    end
    chk("req", {31'b0, instr_req_o}, {31'b0, m_er});
    if (m_er) chk("addr", instr_addr_o, {m_e[31:2], 2'b00});
    ev = instr_rvalid_i && m_q.size() > 0 &&
         !m_q[0].stale && !branch_i;
    chk("fvalid", {31'b0, fifo_valid_o}, {31'b0, ev});
    if (ev) begin
      chk("faddr", fifo_addr_o, m_q[0].a);
      chk("fdata", fifo_rdata_o, instr_rdata_i);
    end
    chk("clear", {31'b0, fifo_clear_o}, {31'b0, branch_i});
    chk("busy", {31'b0, busy_o},
        {31'b0, (m_held || m_q.size() != 0)});
  endtask

  task automatic cyc(bit r, bit b, logic [31:0] ba,
                     bit g, bit rd, bit rv);
    drv(r, b, ba, g, rd, rv);
    #1;
    mcheck();
  endtask

  task automatic adv();
    bit g;
    @(posedge clk);
    if (rst) begin
      mreset();
    end else begin
      g = m_er && instr_gnt_i;
      if (instr_rvalid_i && m_q.size() > 0) void'(m_q.pop_front());
      if (branch_i)
        foreach (m_q[i]) m_q[i].stale = 1;
      if (g) begin
        m_q.push_back('{a: {m_e[31:1], 1'b0}, stale: 0});
        m_fetch = {m_e[31:2], 2'b00} + 32'd4;
        m_held  = 0;
      end else if (m_er) begin
        m_held   = 1;
        m_held_a = m_e;
        if (branch_i) m_fetch = branch_addr_i;
      end else if (branch_i) begin
        m_fetch = branch_addr_i;
      end
      if (branch_i) m_armed = 1;
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    drv(0, 0, 0, 0, 0, 0);
    mreset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // reset state
    cyc(0, 0, 0, 0, 0, 0);
    chk("rst_req", {31'b0, instr_req_o}, 32'h0);
    chk("rst_addr", instr_addr_o, 32'h0);
    chk("rst_busy", {31'b0, busy_o}, 32'h0);
    adv();
    cyc(1, 0, 0, 1, 1, 0);
    chk("no_fetch_before_branch", {31'b0, instr_req_o}, 32'h0);
    adv();

    // boot
    cyc(1, 1, 32'h80, 1, 1, 0);
    chk("boot_a0", instr_addr_o, 32'h80);
    adv();
    cyc(1, 0, 0, 1, 1, 1);
    chk("boot_a1", instr_addr_o, 32'h84);
    chk("boot_f0", fifo_addr_o, 32'h80);
    adv();
    cyc(1, 0, 0, 1, 1, 1);
    chk("boot_a2", instr_addr_o, 32'h88);
    chk("boot_f1", fifo_addr_o, 32'h84);
    adv();
    cyc(0, 0, 0, 0, 1, 1);
    chk("boot_f2", fifo_addr_o, 32'h88);
    adv();

    // unaligned branch
    cyc(1, 1, 32'h102, 1, 1, 0);
    chk("unal_a0", instr_addr_o, 32'h100);
    adv();
    cyc(1, 0, 0, 1, 1, 1);
    chk("unal_a1", instr_addr_o, 32'h104);
    chk("unal_f0", fifo_addr_o, 32'h102);
    adv();
    cyc(0, 0, 0, 0, 1, 1);
    chk("unal_f1", fifo_addr_o, 32'h104);
    adv();

    // branch with two outstanding
    cyc(1, 1, 32'h200, 1, 1, 0);
    adv();
    cyc(1, 0, 0, 1, 1, 0);
    chk("br2_a1", instr_addr_o, 32'h204);
    adv();
    cyc(1, 1, 32'h300, 1, 1, 0);
    chk("br2_clear", {31'b0, fifo_clear_o}, 32'h1);
    chk("br2_credit", {31'b0, instr_req_o}, 32'h0);
    adv();
    cyc(1, 0, 0, 1, 1, 1);
    chk("br2_drop0", {31'b0, fifo_valid_o}, 32'h0);
    chk("br2_clear_off", {31'b0, fifo_clear_o}, 32'h0);
    adv();
    cyc(1, 0, 0, 1, 1, 1);
    chk("br2_drop1", {31'b0, fifo_valid_o}, 32'h0);
    chk("br2_req300", instr_addr_o, 32'h300);
    adv();
    cyc(0, 0, 0, 0, 1, 1);
    chk("br2_f300", fifo_addr_o, 32'h300);
    adv();

    // grant stall
    cyc(1, 0, 0, 0, 1, 0);
    chk("stall_a0", instr_addr_o, 32'h304);
    adv();
    cyc(1, 0, 0, 0, 0, 0);
    chk("stall_a1", instr_addr_o, 32'h304);
    adv();
    cyc(1, 0, 0, 0, 0, 0);
    chk("stall_r2", {31'b0, instr_req_o}, 32'h1);
    chk("stall_a2", instr_addr_o, 32'h304);
    adv();
    cyc(1, 1, 32'h400, 0, 0, 0);
    chk("stall_br", instr_addr_o, 32'h400);
    adv();
    cyc(0, 0, 0, 1, 0, 0);
    chk("stall_held", instr_addr_o, 32'h400);
    adv();
    cyc(0, 0, 0, 0, 1, 1);
    chk("stall_f", fifo_addr_o, 32'h400);
    adv();

    // credit limit
    cyc(1, 0, 0, 1, 1, 0);
    adv();
    cyc(1, 0, 0, 1, 1, 0);
    adv();
    cyc(1, 0, 0, 1, 1, 0);
    chk("cred_req", {31'b0, instr_req_o}, 32'h0);
    chk("cred_busy", {31'b0, busy_o}, 32'h1);
    adv();
    cyc(1, 0, 0, 1, 1, 1);
    adv();
    cyc(1, 0, 0, 1, 1, 0);
    chk("cred_one", {31'b0, instr_req_o}, 32'h1);
    adv();
    cyc(1, 0, 0, 1, 1, 0);
    chk("cred_only_one", {31'b0, instr_req_o}, 32'h0);
    adv();
    cyc(0, 0, 0, 0, 1, 1);
    adv();
    cyc(0, 0, 0, 0, 1, 1);
    adv();

    // address wrap
    cyc(1, 1, 32'hFFFF_FFFC, 1, 1, 0);
    adv();
    cyc(1, 0, 0, 1, 1, 1);
    chk("wrap", instr_addr_o, 32'h0);
    adv();
    cyc(0, 0, 0, 0, 1, 1);
    adv();

    // reset with requests outstanding
    cyc(1, 1, 32'h500, 1, 1, 0);
    adv();
    cyc(1, 0, 0, 1, 1, 0);
    adv();
    rst = 1'b1;
    drv(0, 0, 0, 0, 0, 0);
    adv();
    rst = 1'b0;
    cyc(1, 0, 0, 1, 1, 0);
    chk("mrst_req", {31'b0, instr_req_o}, 32'h0);
    chk("mrst_busy", {31'b0, busy_o}, 32'h0);
    adv();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      bit b;
      bit rv;
      b  = ($urandom % 10) == 0;
      rv = (m_q.size() > 0) && ($urandom % 2 == 1);
      cyc(($urandom % 4) != 0, b, $urandom,
          $urandom % 2 == 1, ($urandom % 4) != 0, rv);
      adv();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
